// File: rtl/multirate_v1_div_32s_17ns_16_seq.sv
// multirate_v1_div_32s_17ns_16_seq
//   Sequential radix-2 restoring divider: signed dividend / unsigned divisor
//   -> saturated signed quotient plus a signed remainder whose sign follows
//   the dividend. One division in flight, constant latency (34 cycles from
//   operand accept to out_valid), divide-by-zero included.
//
// Ports
//   ap_clk, ap_rst         clock (rising), synchronous active-high reset
//   in_valid / in_ready    operand handshake
//   dividend, divisor      signed dividend, unsigned divisor
//   out_valid / out_ready  result handshake
//   quotient               signed, truncated toward zero, saturated
//   remainder              signed, DIVISOR_WIDTH+1 bits
//   ovf, dbz               quotient saturated / divisor was zero
module multirate_v1_div_32s_17ns_16_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 17,
  parameter int QUOT_WIDTH     = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOT_WIDTH-1:0]     quotient,
  output logic [DIVISOR_WIDTH:0]    remainder,
  output logic                      ovf,
  output logic                      dbz
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int SW = DIVISOR_WIDTH;
  localparam int QW = QUOT_WIDTH;
  localparam int CW = $clog2(DW);

  // Largest positive quotient magnitude; the negative side allows one more.
  localparam logic [DW-1:0] QPOS_MAX = DW'((64'd1 << (QW - 1)) - 64'd1);
  localparam logic [DW-1:0] QNEG_MAX = DW'(64'd1 << (QW - 1));
  localparam logic [QW-1:0] QPOS_SAT = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] QNEG_SAT = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic          sign_q;
    logic          sign_r;
    logic [SW-1:0] dvs;
    logic          dbz;
  } req_t;

  typedef struct packed {
    logic [QW-1:0] quotient;
    logic [SW:0]   remainder;
    logic          ovf;
    logic          dbz;
  } rsp_t;

  state_t        state;
  req_t          req;
  rsp_t          rsp;
  logic [DW-1:0] dvd;   // dividend magnitude, consumed MSB first
  logic [DW-1:0] quo;   // quotient magnitude, built LSB in
  logic [SW-1:0] rem;   // running remainder, always < divisor
  logic [CW-1:0] cnt;

  // ---------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------
  logic [SW:0] partial;
  logic [SW:0] diff;
  logic        geq;
  logic [SW-1:0] rem_nxt;

  always_comb begin
    partial = {rem, dvd[DW-1]};
    diff    = partial - {1'b0, req.dvs};
    geq     = (partial >= {1'b0, req.dvs});
    // After a subtract the result is below the divisor, so SW bits suffice;
    // without one the partial itself is below the divisor.
    rem_nxt = geq ? diff[SW-1:0] : partial[SW-1:0];
  end

  // ---------------------------------------------------------------------
  // Sign fix-up and saturation of the finished magnitudes
  // ---------------------------------------------------------------------
  logic [DW-1:0] quo_neg;
  logic [SW:0]   rem_ext;
  rsp_t          fix;

  always_comb begin
    quo_neg = (~quo) + 1'b1;
    rem_ext = {1'b0, rem};
    fix     = '0;
    if (req.dbz) begin
      fix.quotient  = req.sign_q ? QNEG_SAT : QPOS_SAT;
      fix.remainder = '0;
      fix.ovf       = 1'b0;
      fix.dbz       = 1'b1;
    end else begin
      if (!req.sign_q) begin
        fix.ovf      = (quo > QPOS_MAX);
        fix.quotient = fix.ovf ? QPOS_SAT : quo[QW-1:0];
      end else begin
        fix.ovf      = (quo > QNEG_MAX);
        fix.quotient = fix.ovf ? QNEG_SAT : quo_neg[QW-1:0];
      end
      // Remainder is exact even when the quotient saturates.
      fix.remainder = req.sign_r ? ((~rem_ext) + 1'b1) : rem_ext;
      fix.dbz       = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rsp       <= '0;
      req       <= '0;
      dvd       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            req.sign_q <= dividend[DW-1];
            req.sign_r <= dividend[DW-1];
            req.dvs    <= divisor;
            req.dbz    <= (divisor == '0);
            // Two's complement of the most negative value is itself, which
            // read unsigned is exactly its magnitude.
            dvd        <= dividend[DW-1] ? ((~dividend) + 1'b1) : dividend;
            quo        <= '0;
            rem        <= '0;
            cnt        <= CW'(DW - 1);
            in_ready   <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          // Runs the full width even for a zero divisor to keep latency fixed.
          rem <= rem_nxt;
          quo <= {quo[DW-2:0], geq};
          dvd <= {dvd[DW-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          rsp   <= fix;
          state <= DONE;
        end
        DONE: begin
          // Results settle for one cycle in DONE before being presented.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign quotient  = rsp.quotient;
  assign remainder = rsp.remainder;
  assign ovf       = rsp.ovf;
  assign dbz       = rsp.dbz;

endmodule

// File: tb/tb_multirate_v1_div_32s_17ns_16_seq.sv
// Bench for multirate_v1_div_32s_17ns_16_seq: scoreboard of expected results
// pushed at operand accept and popped when out_valid appears.
module tb_multirate_v1_div_32s_17ns_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid, in_ready;
  logic [31:0] dividend;
  logic [16:0] divisor;
  logic        out_valid, out_ready;
  logic [15:0] quotient;
  logic [17:0] remainder;
  logic        ovf, dbz;

  typedef struct packed {
    logic [15:0] q;
    logic [17:0] r;
    logic        ovf;
    logic        dbz;
  } res_t;

  res_t sbq[$];
  res_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc     = 0;

  multirate_v1_div_32s_17ns_16_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference straight from the arithmetic definition.
  function automatic res_t model(input logic [31:0] a, input logic [16:0] b);
    res_t   e;
    longint sa, mag, d, qq, rr, t;
    logic   neg;
    e   = '0;
    sa  = longint'($signed(a));
    neg = (sa < 0);
    mag = neg ? -sa : sa;
    d   = longint'(b);
    if (d == 0) begin
      e.q   = neg ? 16'h8000 : 16'h7FFF;
      e.r   = '0;
      e.dbz = 1'b1;
    end else begin
      qq = mag / d;
      rr = mag % d;
      if (!neg && qq > 32767) begin
        e.q = 16'h7FFF; e.ovf = 1'b1;
      end else if (neg && qq > 32768) begin
        e.q = 16'h8000; e.ovf = 1'b1;
      end else begin
        t   = neg ? -qq : qq;
        e.q = t[15:0];
      end
      t   = neg ? -rr : rr;
      e.r = t[17:0];
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [16:0] b);
    int n;
    @(negedge ap_clk);
    dividend = a; divisor = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge ap_clk); n++; end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    acc = cyc;
    sbq.push_back(model(a, b));
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge ap_clk); n++; end
    chk({tag, "_latency"}, 64'(cyc - acc), 64'd34);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      cur = '0;
    end else begin
      cur = sbq.pop_front();
    end
    chk({tag, "_q"},   64'(quotient),  64'(cur.q));
    chk({tag, "_r"},   64'(remainder), 64'(cur.r));
    chk({tag, "_ovf"}, 64'(ovf),       64'(cur.ovf));
    chk({tag, "_dbz"}, 64'(dbz),       64'(cur.dbz));
  endtask

  task automatic release_res(input string tag);
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy_rise"}, 64'(in_ready),  64'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [16:0] b);
    send(a, b);
    wait_res(tag);
    release_res(tag);
  endtask

  initial begin
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge ap_clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient",  64'(quotient),  64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_dbz",       64'(dbz),       64'd0);
    ap_rst = 1'b0;

    run("basic",     32'd1000000,  17'd100);
    run("neg7_2",    -32'sd7,      17'd2);
    run("pos7_2",    32'd7,        17'd2);
    run("sat_pos",   32'h7FFFFFFF, 17'd1);
    run("min_64k",   32'h80000000, 17'd65536);
    run("min_65535", 32'h80000000, 17'd65535);  // |Q| = 32768 exactly
    run("min_65534", 32'h80000000, 17'd65534);  // |Q| = 32769 saturates
    run("big_div",   32'd123456,   17'h1FFFF);
    run("dbz_neg",   -32'sd5,      17'd0);
    run("dbz_pos",   32'd5,        17'd0);
    run("dbz_zero",  32'd0,        17'd0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [16:0] b;
      a = $urandom;
      b = 17'($urandom_range(1, 131071));
      if (i[0]) b = 17'($urandom_range(1, 15));
      run("rand", a, b);
    end

    // Backpressure with a producer already holding the next operands.
    send(-32'sd1234567, 17'd300);
    wait_res("bp");
    @(negedge ap_clk);
    dividend = 32'd7; divisor = 17'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld",  64'(out_valid), 64'd1);
      chk("bp_rdy",  64'(in_ready),  64'd0);
      chk("bp_q",    64'(quotient),  64'(cur.q));
      chk("bp_r",    64'(remainder), 64'(cur.r));
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    chk("bp_vld_drop", 64'(out_valid), 64'd0);
    chk("bp_rdy_rise", 64'(in_ready),  64'd1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    acc = cyc;
    sbq.push_back(model(32'd7, 17'd2));
    chk("bp_held_accept", 64'(in_ready), 64'd0);
    wait_res("bp_next");
    release_res("bp_next");

    // Reset in the middle of CALC drops the operation.
    send(32'd987654, 17'd321);
    repeat (15) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    sbq.delete();
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready),  64'd1);
    chk("mid_rst_q",   64'(quotient),  64'd0);
    chk("mid_rst_r",   64'(remainder), 64'd0);
    run("post_rst", 32'd100, 17'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
